acam_fifo_reader: RTL and testbench

- FPGA-side read engine for the ACAM TDC readout FIFOs. It sits between the ACAM pins (address, rd_n, data bus, EF1/EF2) and the timestamp-processing pipeline.
- Polls the two ACAM empty flags and issues read strobes at address 8 (FIFO1, channels 0-3) or 9 (FIFO2, channels 4-7).
- Captures each 28-bit word and presents it with a channel tag on a valid/ready stream.

---
 rtl/acam_reader_pkg.sv | 20 ++
 rtl/acam_ef_sync.sv | 27 ++
 rtl/acam_fifo_reader.sv | 170 +++++++++++++++++
 tb/tb_acam_fifo_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acam_reader_pkg.sv
// Shared types and constants for the ACAM TDC FIFO read engine.
package acam_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD_LOW,
        RD_HIGH,
        SETTLE
    } t_acam_rd_state;

    localparam logic [3:0] c_ACAM_ADDR_FIFO1 = 4'd8;
    localparam logic [3:0] c_ACAM_ADDR_FIFO2 = 4'd9;

    typedef struct packed {
        logic [27:0] data;
        logic [2:0]  chan;
    } t_acam_ts;

endpackage

// File: rtl/acam_ef_sync.sv
// Two-flop synchroniser for the asynchronous ACAM empty flags; resets to "empty".
module acam_ef_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ef1_i,
    input  logic ef2_i,
    output logic ef1_o,
    output logic ef2_o
);

    logic [1:0] meta_q;
    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
        end else begin
            meta_q <= {ef2_i, ef1_i};
            sync_q <= meta_q;
        end
    end

    assign ef1_o = sync_q[0];
    assign ef2_o = sync_q[1];

endmodule

// File: rtl/acam_fifo_reader.sv
// ACAM FIFO1/FIFO2 read engine with valid/ready timestamp output.
// Optional per-FIFO read counters are built when ACAM_READ_STATS_EN is defined.
//
// state   | meaning
// IDLE    | wait for enable, free output slot and a non-empty FIFO
// SETUP   | address stable, rd_n high for one cycle
// RD_LOW  | rd_n low for g_rd_low_cycles, data captured on the last one
// RD_HIGH | rd_n high recovery, word presented on the first cycle
// SETTLE  | wait until the empty flags are trustworthy again
module acam_fifo_reader
    import acam_reader_pkg::*;
#(
    parameter int g_rd_low_cycles    = 4,
    parameter int g_rd_high_cycles   = 2,
    parameter int g_ef_settle_cycles = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic        ef1_i,
    input  logic        ef2_i,
    input  logic [27:0] acam_data_i,
    output logic [3:0]  acam_addr_o,
    output logic        acam_rd_n_o,
    output logic        acam_wr_n_o,
    output logic [27:0] ts_data_o,
    output logic [2:0]  ts_chan_o,
    output logic        ts_valid_o,
    input  logic        ts_ready_i,
    output logic        busy_o
`ifdef ACAM_READ_STATS_EN
    ,
    input  logic        stats_clr_i,
    output logic [31:0] rd_cnt1_o,
    output logic [31:0] rd_cnt2_o
`endif
);

    localparam logic [7:0] c_LOW_LD    = 8'(g_rd_low_cycles - 1);
    localparam logic [7:0] c_HIGH_LD   = 8'(g_rd_high_cycles - 1);
    localparam logic [7:0] c_SETTLE_LD = 8'(g_ef_settle_cycles - 1);

    t_acam_rd_state state_q;
    logic [7:0]     tmr_q;
    logic [7:0]     settle_q;
    logic           sel_q;
    logic           ptr_q;
    logic [27:0]    cap_q;
    logic           rd_n_q;
    logic [3:0]     addr_q;
    t_acam_ts       ts_q;
    logic           valid_q;
    logic           ef1_s;
    logic           ef2_s;
    logic           start_d;
    logic           sel_d;
`ifdef ACAM_READ_STATS_EN
    logic [31:0]    cnt1_q;
    logic [31:0]    cnt2_q;
`endif

    acam_ef_sync u_ef_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .ef1_i   (ef1_i),
        .ef2_i   (ef2_i),
        .ef1_o   (ef1_s),
        .ef2_o   (ef2_s)
    );

    // ptr_q is the FIFO preferred when both hold data; sel_d = 1 means FIFO2.
    always_comb begin
        start_d = enable_i && (!valid_q || ts_ready_i) && (!ef1_s || !ef2_s);
        sel_d   = (!ef1_s && !ef2_s) ? ptr_q : ef1_s;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            settle_q <= '0;
            sel_q    <= 1'b0;
            ptr_q    <= 1'b0;
            cap_q    <= '0;
            rd_n_q   <= 1'b1;
            addr_q   <= c_ACAM_ADDR_FIFO1;
            ts_q     <= '0;
            valid_q  <= 1'b0;
`ifdef ACAM_READ_STATS_EN
            cnt1_q   <= '0;
            cnt2_q   <= '0;
`endif
        end else begin
            if (settle_q != 8'd0)
                settle_q <= settle_q - 8'd1;
            if (valid_q && ts_ready_i)
                valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        sel_q   <= sel_d;
                        ptr_q   <= !sel_d;
                        addr_q  <= sel_d ? c_ACAM_ADDR_FIFO2 : c_ACAM_ADDR_FIFO1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    rd_n_q  <= 1'b0;
                    tmr_q   <= c_LOW_LD;
                    state_q <= RD_LOW;
                end
                RD_LOW: begin
                    if (tmr_q == 8'd0) begin
                        cap_q    <= acam_data_i;
                        rd_n_q   <= 1'b1;
                        tmr_q    <= c_HIGH_LD;
                        settle_q <= c_SETTLE_LD;
                        state_q  <= RD_HIGH;
                    end else begin
                        tmr_q <= tmr_q - 8'd1;
                    end
                end
                RD_HIGH: begin
                    if (tmr_q == c_HIGH_LD) begin
                        ts_q.data <= cap_q;
                        ts_q.chan <= {sel_q, cap_q[27:26]};
                        valid_q   <= 1'b1;
`ifdef ACAM_READ_STATS_EN
                        if (sel_q)
                            cnt2_q <= cnt2_q + 32'd1;
                        else
                            cnt1_q <= cnt1_q + 32'd1;
`endif
                    end
                    if (tmr_q == 8'd0)
                        state_q <= SETTLE;
                    else
                        tmr_q <= tmr_q - 8'd1;
                end
                SETTLE: begin
                    // The IDLE cycle that follows is the last settle cycle.
                    if (settle_q <= 8'd1)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

`ifdef ACAM_READ_STATS_EN
            if (stats_clr_i) begin
                cnt1_q <= '0;
                cnt2_q <= '0;
            end
`endif
        end
    end

    assign acam_addr_o = addr_q;
    assign acam_rd_n_o = rd_n_q;
    assign acam_wr_n_o = 1'b1;
    assign ts_data_o   = ts_q.data;
    assign ts_chan_o   = ts_q.chan;
    assign ts_valid_o  = valid_q;
    assign busy_o      = (state_q != IDLE);
`ifdef ACAM_READ_STATS_EN
    assign rd_cnt1_o   = cnt1_q;
    assign rd_cnt2_o   = cnt2_q;
`endif

endmodule

// File: tb/tb_acam_fifo_reader.sv
// Directed bench for acam_fifo_reader with a behavioural ACAM FIFO model.
// Exercises the read counters too when ACAM_READ_STATS_EN is defined.
module tb_acam_fifo_reader;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        enable_i;
    logic        ef1_i;
    logic        ef2_i;
    logic [27:0] acam_data_i;
    logic [3:0]  acam_addr_o;
    logic        acam_rd_n_o;
    logic        acam_wr_n_o;
    logic [27:0] ts_data_o;
    logic [2:0]  ts_chan_o;
    logic        ts_valid_o;
    logic        ts_ready_i;
    logic        busy_o;
`ifdef ACAM_READ_STATS_EN
    logic        stats_clr_i;
    logic [31:0] rd_cnt1_o;
    logic [31:0] rd_cnt2_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [27:0] fifo1[$];
    logic [27:0] fifo2[$];
    logic [27:0] got_data[$];
    logic [2:0]  got_chan[$];
    logic [3:0]  addr_log[$];
    int          pulses = 0;
    logic        rd_prev = 1'b1;
    logic [3:0]  fall_addr = 4'd8;

    acam_fifo_reader dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .enable_i    (enable_i),
        .ef1_i       (ef1_i),
        .ef2_i       (ef2_i),
        .acam_data_i (acam_data_i),
        .acam_addr_o (acam_addr_o),
        .acam_rd_n_o (acam_rd_n_o),
        .acam_wr_n_o (acam_wr_n_o),
        .ts_data_o   (ts_data_o),
        .ts_chan_o   (ts_chan_o),
        .ts_valid_o  (ts_valid_o),
        .ts_ready_i  (ts_ready_i),
        .busy_o      (busy_o)
`ifdef ACAM_READ_STATS_EN
        ,
        .stats_clr_i (stats_clr_i),
        .rd_cnt1_o   (rd_cnt1_o),
        .rd_cnt2_o   (rd_cnt2_o)
`endif
    );

    initial forever #4 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rd_low(input string tag);
        int n = 0;
        while (acam_rd_n_o !== 1'b0 && n < 200) begin tick(); n++; end
        check(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (ts_valid_o !== 1'b1 && n < 200) begin tick(); n++; end
        check(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic wait_got(input int target, input string tag);
        int n = 0;
        while (got_data.size() < target && n < 500) begin tick(); n++; end
        check(tag, 32'(got_data.size() >= target), 32'd1);
    endtask

    task automatic pulse_reset();
        rst_n_i = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
        tick();
    endtask

    // ACAM model: pops on a completed read (rd_n rising outside reset), drives data while rd_n low.
    initial forever begin
        logic [27:0] dummy;
        @(negedge clk_i);
        if (rd_prev === 1'b0 && acam_rd_n_o === 1'b1 && rst_n_i === 1'b1) begin
            if (fall_addr == 4'd8 && fifo1.size() > 0) dummy = fifo1.pop_front();
            if (fall_addr == 4'd9 && fifo2.size() > 0) dummy = fifo2.pop_front();
        end
        if (rd_prev === 1'b1 && acam_rd_n_o === 1'b0) begin
            pulses++;
            addr_log.push_back(acam_addr_o);
            fall_addr = acam_addr_o;
        end
        rd_prev = acam_rd_n_o;
        if (ts_valid_o === 1'b1 && ts_ready_i === 1'b1) begin
            got_data.push_back(ts_data_o);
            got_chan.push_back(ts_chan_o);
        end
        ef1_i = (fifo1.size() == 0);
        ef2_i = (fifo2.size() == 0);
        acam_data_i = 28'h0;
        if (acam_rd_n_o === 1'b0) begin
            if (acam_addr_o == 4'd8 && fifo1.size() > 0) acam_data_i = fifo1[0];
            if (acam_addr_o == 4'd9 && fifo2.size() > 0) acam_data_i = fifo2[0];
        end
    end

    initial begin
        int p0, g0, al0, n, lowc;
        logic hold_ok;
        logic [27:0] exp_d [6];
        logic [2:0]  exp_c [6];
        logic [3:0]  exp_a [6];

        rst_n_i = 1'b0; enable_i = 1'b0; ts_ready_i = 1'b0;
        ef1_i = 1'b1; ef2_i = 1'b1; acam_data_i = '0;
`ifdef ACAM_READ_STATS_EN
        stats_clr_i = 1'b0;
`else
        $display("read statistics not built");
`endif
        repeat (3) tick();
        check("rst_rd_n", 32'(acam_rd_n_o), 32'd1);
        check("rst_wr_n", 32'(acam_wr_n_o), 32'd1);
        check("rst_addr", 32'(acam_addr_o), 32'd8);
        check("rst_valid", 32'(ts_valid_o), 32'd0);
        check("rst_data", 32'(ts_data_o), 32'd0);
        check("rst_chan", 32'(ts_chan_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst_n_i = 1'b1; enable_i = 1'b1;
        repeat (4) tick();
        check("idle_no_read", 32'(pulses), 32'd0);

        // Single word, channel 2, FIFO1
        p0 = pulses;
        fifo1.push_back(28'h8001234);
        wait_rd_low("t1_rd_fall");
        check("t1_addr", 32'(acam_addr_o), 32'd8);
        lowc = 1; n = 0;
        while (ts_valid_o !== 1'b1 && n < 50) begin
            tick(); n++;
            if (acam_rd_n_o === 1'b0) lowc++;
        end
        check("t1_latency", 32'(n), 32'd5);
        check("t1_low_cycles", 32'(lowc), 32'd4);
        check("t1_data", 32'(ts_data_o), 32'h8001234);
        check("t1_chan", 32'(ts_chan_o), 32'd2);
        check("t1_busy", 32'(busy_o), 32'd1);
        check("t1_pulses", 32'(pulses - p0), 32'd1);
        ts_ready_i = 1'b1; tick(); ts_ready_i = 1'b0;
        check("t1_valid_clr", 32'(ts_valid_o), 32'd0);
        pulse_reset();

        // Round robin between FIFO1 (ch0-2) and FIFO2 (ch5-7)
        ts_ready_i = 1'b1;
        g0 = got_data.size(); al0 = addr_log.size();
        exp_d = '{28'h00000A0, 28'h40000B5, 28'h40000A1, 28'h80000B6, 28'h80000A2, 28'hC0000B7};
        exp_c = '{3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd7};
        exp_a = '{4'd8, 4'd9, 4'd8, 4'd9, 4'd8, 4'd9};
        fifo1.push_back(28'h00000A0); fifo1.push_back(28'h40000A1); fifo1.push_back(28'h80000A2);
        fifo2.push_back(28'h40000B5); fifo2.push_back(28'h80000B6); fifo2.push_back(28'hC0000B7);
        wait_got(g0 + 6, "t2_done");
        for (int i = 0; i < 6; i++) begin
            if (got_data.size() > g0 + i) begin
                check($sformatf("t2_data%0d", i), 32'(got_data[g0 + i]), 32'(exp_d[i]));
                check($sformatf("t2_chan%0d", i), 32'(got_chan[g0 + i]), 32'(exp_c[i]));
            end
            if (addr_log.size() > al0 + i)
                check($sformatf("t2_addr%0d", i), 32'(addr_log[al0 + i]), 32'(exp_a[i]));
        end

        // Backpressure: one read only while the word is unaccepted
        ts_ready_i = 1'b0;
        p0 = pulses;
        fifo1.push_back(28'hC000333); fifo1.push_back(28'h4000444);
        wait_valid("t3_valid1");
        hold_ok = 1'b1;
        repeat (100) begin
            tick();
            if (ts_valid_o !== 1'b1 || ts_data_o !== 28'hC000333 || ts_chan_o !== 3'd3) hold_ok = 1'b0;
        end
        check("t3_hold", 32'(hold_ok), 32'd1);
        check("t3_pulses1", 32'(pulses - p0), 32'd1);
        ts_ready_i = 1'b1; tick(); ts_ready_i = 1'b0;
        check("t3_valid_clr", 32'(ts_valid_o), 32'd0);
        wait_valid("t3_valid2");
        check("t3_data2", 32'(ts_data_o), 32'h4000444);
        check("t3_chan2", 32'(ts_chan_o), 32'd1);
        check("t3_pulses2", 32'(pulses - p0), 32'd2);
        ts_ready_i = 1'b1; tick();

        // enable dropped during RD_LOW
        g0 = got_data.size(); p0 = pulses;
        fifo2.push_back(28'h0000555); fifo2.push_back(28'hC000666);
        wait_rd_low("t4_rd_fall");
        enable_i = 1'b0;
        wait_got(g0 + 1, "t4_got1");
        if (got_data.size() > g0) begin
            check("t4_data1", 32'(got_data[g0]), 32'h0000555);
            check("t4_chan1", 32'(got_chan[g0]), 32'd4);
        end
        repeat (40) tick();
        check("t4_no_read", 32'(pulses - p0), 32'd1);
        check("t4_pending", 32'(fifo2.size()), 32'd1);
        enable_i = 1'b1;
        wait_got(g0 + 2, "t4_got2");
        if (got_data.size() > g0 + 1) begin
            check("t4_data2", 32'(got_data[g0 + 1]), 32'hC000666);
            check("t4_chan2", 32'(got_chan[g0 + 1]), 32'd7);
        end

        // Reset during RD_LOW
        g0 = got_data.size();
        fifo1.push_back(28'h4000777);
        wait_rd_low("t5_rd_fall");
        tick();
        rst_n_i = 1'b0;
        tick();
        check("t5_rd_n", 32'(acam_rd_n_o), 32'd1);
        check("t5_valid", 32'(ts_valid_o), 32'd0);
        tick(); tick();
        rst_n_i = 1'b1;
        check("t5_pending", 32'(fifo1.size()), 32'd1);
        wait_got(g0 + 1, "t5_got");
        if (got_data.size() > g0) begin
            check("t5_data", 32'(got_data[g0]), 32'h4000777);
            check("t5_chan", 32'(got_chan[g0]), 32'd1);
        end
        check("t5_drained", 32'(fifo1.size()), 32'd0);

`ifdef ACAM_READ_STATS_EN
        pulse_reset();
        check("st_rst1", rd_cnt1_o, 32'd0);
        g0 = got_data.size();
        for (int i = 0; i < 5; i++) fifo1.push_back(28'(i));
        for (int i = 0; i < 3; i++) fifo2.push_back(28'(16 + i));
        wait_got(g0 + 8, "st_got");
        check("st_cnt1", rd_cnt1_o, 32'd5);
        check("st_cnt2", rd_cnt2_o, 32'd3);
        stats_clr_i = 1'b1; tick(); stats_clr_i = 1'b0;
        check("st_clr1", rd_cnt1_o, 32'd0);
        check("st_clr2", rd_cnt2_o, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
